// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps one memory read outstanding, delivers fetched
// words to the IR with zero bubbles, buffers one word while the IR is stalled,
// and drains reads that a redirect cancelled before restarting at the target.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        mem_read,
  output logic [15:0] mem_address,
  output logic        ir_load,
  output logic [15:0] ir_data,
  output logic [15:0] ir_pc
);

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDiscard
  } state_e;

  localparam logic [15:0] PcMask = 16'hFFFE;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buffer_q, buffer_d;
  logic [15:0] discard_addr_q, discard_addr_d;

  logic [15:0] redirect_target;
  logic [15:0] pc_inc;

  // Raw outputs before the reset gate.
  logic        mem_read_c;
  logic [15:0] mem_address_c;
  logic        ir_load_c;
  logic [15:0] ir_data_c;
  logic [15:0] ir_pc_c;

  assign redirect_target = redirect_pc & PcMask;
  assign pc_inc          = pc_q + 16'd2;

  // State registers; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StFetch;
      pc_q           <= RESET_PC & PcMask;
      buffer_q       <= 16'h0000;
      discard_addr_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      buffer_q       <= buffer_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  // Next-state and output decode; redirect outranks stall and mem_resp.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buffer_d       = buffer_q;
    discard_addr_d = discard_addr_q;
    mem_read_c     = 1'b0;
    mem_address_c  = pc_q;
    ir_load_c      = 1'b0;
    ir_data_c      = 16'h0000;
    ir_pc_c        = 16'h0000;

    unique case (state_q)
      StFetch: begin
        mem_read_c    = 1'b1;
        mem_address_c = pc_q;
        if (redirect) begin
          pc_d = redirect_target;
          if (!mem_resp) begin
            // Read still in flight: remember its address so it stays stable.
            discard_addr_d = pc_q;
            state_d        = StDiscard;
          end
        end else if (mem_resp) begin
          if (stall) begin
            buffer_d = mem_rdata;
            state_d  = StHold;
          end else begin
            ir_load_c = 1'b1;
            ir_data_c = mem_rdata;
            ir_pc_c   = pc_q;
            pc_d      = pc_inc;
          end
        end
      end

      StHold: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = StFetch;
        end else if (!stall) begin
          ir_load_c = 1'b1;
          ir_data_c = buffer_q;
          ir_pc_c   = pc_q;
          pc_d      = pc_inc;
          state_d   = StFetch;
        end
      end

      StDiscard: begin
        mem_read_c    = 1'b1;
        mem_address_c = discard_addr_q;
        if (redirect) begin
          pc_d = redirect_target;
        end
        if (mem_resp) begin
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Reset is asynchronous, so the request and IR strobe are gated directly.
  assign mem_read    = mem_read_c & ~reset;
  assign mem_address = mem_address_c;
  assign ir_load     = ir_load_c & ~reset;
  assign ir_data     = ir_load ? ir_data_c : 16'h0000;
  assign ir_pc       = ir_load ? ir_pc_c : 16'h0000;

`ifndef SYNTHESIS
  a_idle_zero : assert property (@(posedge clk)
      !ir_load |-> (ir_data == 16'h0000 && ir_pc == 16'h0000));
  a_redirect_blocks_load : assert property (@(posedge clk) redirect |-> !ir_load);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic. Expected
// deliveries come from a program-order stream model; a monitor pops and
// compares on every ir_load.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        ir_load;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;

  fetch_unit #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .ir_load    (ir_load),
    .ir_data    (ir_data),
    .ir_pc      (ir_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] next_pc;
  int          n_total = 0;
  int          n_bad = 0;
  int          n_loads = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ {a[7:0], a[15:8]} ^ 16'h1F2E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Program stream restarts at a new address; everything pending is dropped.
  task automatic sb_restart(input logic [15:0] pc);
    exp_q.delete();
    next_pc = pc;
  endtask

  task automatic sb_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 16'd2;
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic rst, input logic rsp, input logic stl, input logic rdr,
                       input logic [15:0] rpc);
    logic        rsp_eff;
    logic [15:0] rdata;
    @(posedge clk);
    #1;
    rsp_eff = rsp && (rst || mem_read);
    rdata   = rsp_eff ? mem_word(mem_address) : 16'($urandom);
    reset       = rst;
    mem_resp    = rsp_eff;
    mem_rdata   = rdata;
    stall       = stl;
    redirect    = rdr && !rst;
    redirect_pc = rpc;
    if (rst) sb_restart(RESET_PC);
    else if (rdr) sb_restart(rpc & 16'hFFFE);
    sb_fill();
    #3;
  endtask

  task automatic expect_out(input string tag, input logic rd, input logic [15:0] addr,
                            input logic ld, input logic [15:0] pc);
    chk({tag, ".mem_read"}, 32'(mem_read), 32'(rd));
    if (rd) chk({tag, ".mem_address"}, 32'(mem_address), 32'(addr));
    chk({tag, ".ir_load"}, 32'(ir_load), 32'(ld));
    if (ld) chk({tag, ".ir_pc"}, 32'(ir_pc), 32'(pc));
  endtask

  task automatic monitor();
    logic        pend;
    logic [15:0] paddr;
    exp_t        e;
    pend  = 1'b0;
    paddr = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        chk("rst_ir_load", 32'(ir_load), 32'h0);
      end else if (pend) begin
        chk("req_held", 32'(mem_read), 32'h1);
        chk("addr_stable", 32'(mem_address), 32'(paddr));
      end
      if (ir_load) begin
        n_loads++;
        chk("load_blocked", 32'({stall, redirect, reset}), 32'h0);
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL sb_empty: got load pc %h expected none", ir_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ir_pc", 32'(ir_pc), 32'(e.pc));
          chk("sb_ir_data", 32'(ir_data), 32'(e.data));
        end
      end else begin
        chk("idle_zero", {ir_pc, ir_data}, 32'h0);
      end
      pend  = mem_read && !mem_resp && !reset;
      paddr = mem_address;
    end
  endtask

  initial begin
    int rst_left;
    int n0;
    logic r_rst;
    fork
      monitor();
    join_none

    // Reset with mem_resp pulses
    sb_restart(RESET_PC);
    sb_fill();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    expect_out("reset", 1'b0, 16'h0, 1'b0, 16'h0);
    chk("reset.ir_data", 32'(ir_data), 32'h0);
    chk("reset.ir_pc", 32'(ir_pc), 32'h0);

    // Back-to-back fetch with single-cycle memory
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);  expect_out("first", 1'b1, RESET_PC, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);  expect_out("b2b0", 1'b1, 16'h0000, 1'b1, 16'h0000);
    chk("b2b0.ir_data", 32'(ir_data), 32'(mem_word(16'h0000)));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);  expect_out("b2b1", 1'b1, 16'h0002, 1'b1, 16'h0002);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);  expect_out("b2b2", 1'b1, 16'h0004, 1'b1, 16'h0004);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);  expect_out("b2b3", 1'b1, 16'h0006, 1'b1, 16'h0006);

    // Redirect while read of 0x0008 outstanding, second redirect while draining
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h2222); expect_out("disc0", 1'b1, 16'h0008, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h3001); expect_out("disc1", 1'b1, 16'h0008, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);    expect_out("disc2", 1'b1, 16'h0008, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);    expect_out("disc3", 1'b1, 16'h0008, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);    expect_out("disc4", 1'b1, 16'h3000, 1'b1, 16'h3000);

    // Redirect beats mem_resp, then stall at 0x0010 for three held cycles
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010); expect_out("rdr_resp", 1'b1, 16'h3002, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);    expect_out("stall0", 1'b1, 16'h0010, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);  expect_out("hold", 1'b0, 16'h0, 1'b0, 16'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);    expect_out("release", 1'b0, 16'h0, 1'b1, 16'h0010);
    chk("release.ir_data", 32'(ir_data), 32'(mem_word(16'h0010)));

    // Redirect with mem_resp and stall: no HOLD entered
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h4000); expect_out("rdr_stall", 1'b1, 16'h0012, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);    expect_out("no_hold", 1'b1, 16'h4000, 1'b0, 16'h0);
    // Redirect out of HOLD, then wrap past 0xFFFE
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFD); expect_out("hold_rdr", 1'b0, 16'h0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);    expect_out("wrap0", 1'b1, 16'hFFFC, 1'b1, 16'hFFFC);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);    expect_out("wrap1", 1'b1, 16'hFFFE, 1'b1, 16'hFFFE);

    // Reset during DISCARD with mem_resp pulses
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234); expect_out("wrap2", 1'b1, 16'h0000, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);    expect_out("disc5", 1'b1, 16'h0000, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);    expect_out("rst_disc0", 1'b0, 16'h0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);    expect_out("rst_disc1", 1'b0, 16'h0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);    expect_out("restart", 1'b1, RESET_PC, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);    expect_out("restart1", 1'b1, RESET_PC, 1'b1, RESET_PC);

    // Randomized traffic
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      r_rst = (rst_left > 0);
      drive(r_rst, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, 16'($urandom));
    end

    // Drain: free-flowing memory must keep delivering
    n0 = n_loads;
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    #1;
    chk("drain_progress", 32'(n_loads - n0 >= 35), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
